// File: rtl/i2s_tx_word_slicer.sv
// Slices 32-bit TDM slot samples MSB-first into bytes for the I2S/TDM transmit PHY,
// masking unused LSBs and enforcing the configured frame length.
module i2s_tx_word_slicer (
  input  logic        bclk,
  input  logic        rst_n,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  input  logic        i_enable,
  input  logic [4:0]  i_tdm_num,
  input  logic [5:0]  i_valid_word_width,
  output logic [31:0] o_frame_num,
  output logic        o_error
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] word_r;
  logic [1:0]  byte_idx_r;
  logic        last_flag_r;
  logic [4:0]  slot_cnt_r;
  logic        in_fire_s;
  logic        out_fire_s;
  logic        last_byte_s;
  logic        expected_last_s;
  logic [31:0] masked_s;

  // Keeps the top 'width' bits; 0 or anything above 32 selects the full slot.
  function automatic logic [31:0] width_mask(input logic [5:0] width);
    logic [5:0] eff;
    eff = ((width == 6'd0) || (width > 6'd32)) ? 6'd32 : width;
    return 32'hFFFF_FFFF << (6'd32 - eff);
  endfunction

  assign last_byte_s     = (byte_idx_r == 2'd3);
  assign in_fire_s       = s_axis_tvalid && s_axis_tready;
  assign out_fire_s      = m_axis_tvalid && m_axis_tready;
  // 5-bit wraparound makes tdm_num=0 mean a 32-slot frame.
  assign expected_last_s = (slot_cnt_r == (i_tdm_num - 5'd1));
  assign masked_s        = s_axis_tdata & width_mask(i_valid_word_width);

  // State register.
  always_ff @(posedge bclk) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state: a reload on the final byte keeps the stream bubble-free.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (in_fire_s) state_next_s = ST_SHIFT;
        else           state_next_s = ST_EMPTY;
      end
      ST_SHIFT: begin
        if (out_fire_s && last_byte_s && !in_fire_s) state_next_s = ST_EMPTY;
        else                                         state_next_s = ST_SHIFT;
      end
      default: state_next_s = ST_EMPTY;
    endcase
  end

  // Output decode from the holding register.
  always_comb begin
    m_axis_tvalid = (state_r == ST_SHIFT);
    m_axis_tlast  = (state_r == ST_SHIFT) && last_flag_r && last_byte_s;
    case (byte_idx_r)
      2'd0:    m_axis_tdata = word_r[31:24];
      2'd1:    m_axis_tdata = word_r[23:16];
      2'd2:    m_axis_tdata = word_r[15:8];
      2'd3:    m_axis_tdata = word_r[7:0];
      default: m_axis_tdata = 8'd0;
    endcase
    if (rst_n) begin
      s_axis_tready = i_enable && ((state_r == ST_EMPTY) || (last_byte_s && m_axis_tready));
    end else begin
      s_axis_tready = 1'b0;
    end
  end

  // Holding register and byte pointer.
  always_ff @(posedge bclk) begin
    if (!rst_n) begin
      word_r      <= 32'd0;
      byte_idx_r  <= 2'd0;
      last_flag_r <= 1'b0;
    end else if (in_fire_s) begin
      word_r      <= masked_s;
      byte_idx_r  <= 2'd0;
      last_flag_r <= expected_last_s;
    end else if (out_fire_s) begin
      byte_idx_r  <= byte_idx_r + 2'd1;
    end else begin
      byte_idx_r  <= byte_idx_r;
    end
  end

  // Slot counter; an early source tlast resyncs the count to the source framing.
  always_ff @(posedge bclk) begin
    if (!rst_n) begin
      slot_cnt_r <= 5'd0;
    end else if ((state_r == ST_EMPTY) && !i_enable) begin
      slot_cnt_r <= 5'd0;
    end else if (in_fire_s) begin
      if (expected_last_s || s_axis_tlast) slot_cnt_r <= 5'd0;
      else                                 slot_cnt_r <= slot_cnt_r + 5'd1;
    end else begin
      slot_cnt_r <= slot_cnt_r;
    end
  end

  // Sticky frame-length error and emitted-frame counter.
  always_ff @(posedge bclk) begin
    if (!rst_n) begin
      o_error     <= 1'b0;
      o_frame_num <= 32'd0;
    end else begin
      if (in_fire_s && (s_axis_tlast != expected_last_s)) o_error <= 1'b1;
      else                                                o_error <= o_error;
      if (out_fire_s && m_axis_tlast) o_frame_num <= o_frame_num + 32'd1;
      else                            o_frame_num <= o_frame_num;
    end
  end

endmodule

// File: tb/tb_i2s_tx_word_slicer.sv
// Directed bench for i2s_tx_word_slicer: a vector table streamed back to back,
// plus hand-written backpressure, framing, enable and reset sequences.
module tb_i2s_tx_word_slicer;

  logic        bclk;
  logic        rst_n;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        i_enable;
  logic [4:0]  i_tdm_num;
  logic [5:0]  i_valid_word_width;
  logic [31:0] o_frame_num;
  logic        o_error;

  i2s_tx_word_slicer dut (
    .bclk               (bclk),
    .rst_n              (rst_n),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tlast       (s_axis_tlast),
    .s_axis_tready      (s_axis_tready),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tready      (m_axis_tready),
    .i_enable           (i_enable),
    .i_tdm_num          (i_tdm_num),
    .i_valid_word_width (i_valid_word_width),
    .o_frame_num        (o_frame_num),
    .o_error            (o_error)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [5:0]  width;
    logic [4:0]  tdm;
    logic [31:0] exp_word;
    logic        exp_last;
  } vec_t;

  vec_t        tbl [0:8];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [7:0]  got_data [$];
  logic        got_last [$];
  int          got_cyc  [$];
  int          in_cyc   [$];
  logic [7:0]  exp_data [$];
  logic        exp_last [$];

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  always @(posedge bclk) cyc <= cyc + 1;

  // Record every real handshake just before the edge that completes it.
  always @(negedge bclk) begin
    if (rst_n === 1'b1 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      got_data.push_back(m_axis_tdata);
      got_last.push_back(m_axis_tlast);
      got_cyc.push_back(cyc);
    end
    if (rst_n === 1'b1 && s_axis_tvalid === 1'b1 && s_axis_tready === 1'b1) begin
      in_cyc.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic clear_q();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    in_cyc.delete();
    exp_data.delete();
    exp_last.delete();
  endtask

  task automatic expect_word(input logic [31:0] w, input logic l);
    for (int b = 0; b < 4; b++) begin
      exp_data.push_back(w[31-8*b -: 8]);
      exp_last.push_back(l && (b == 3));
    end
  endtask

  // Presents a word and returns at #1 after the edge on which it was accepted.
  task automatic send_word(input logic [31:0] d, input logic l);
    logic acc;
    logic done;
    int   t;
    done = 1'b0;
    t    = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!done && t < 50) begin
      @(negedge bclk);
      acc = s_axis_tready;
      tick();
      if (acc) done = 1'b1;
      t++;
    end
    s_axis_tvalid = 1'b0;
    chk($sformatf("accept_%h", d), {31'd0, done}, 32'd1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (got_data.size() < exp_data.size() && t < 400) begin
      tick();
      t++;
    end
    repeat (3) tick();
  endtask

  task automatic compare_stream(input string name);
    chk({name, "_count"}, got_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      chk($sformatf("%s_byte%0d", name, i), {24'd0, got_data[i]}, {24'd0, exp_data[i]});
      chk($sformatf("%s_last%0d", name, i), {31'd0, got_last[i]}, {31'd0, exp_last[i]});
    end
  endtask

  initial begin
    tbl[0] = '{32'h1122_3344, 1'b0, 6'd32, 5'd2, 32'h1122_3344, 1'b0};
    tbl[1] = '{32'hAABB_CCDD, 1'b1, 6'd32, 5'd2, 32'hAABB_CCDD, 1'b1};
    tbl[2] = '{32'h1234_5678, 1'b1, 6'd20, 5'd1, 32'h1234_5000, 1'b1};
    tbl[3] = '{32'hDEAD_BEEF, 1'b1, 6'd0,  5'd1, 32'hDEAD_BEEF, 1'b1};
    tbl[4] = '{32'hCAFE_F00D, 1'b1, 6'd40, 5'd1, 32'hCAFE_F00D, 1'b1};
    tbl[5] = '{32'hFFFF_FFFF, 1'b1, 6'd1,  5'd1, 32'h8000_0000, 1'b1};
    tbl[6] = '{32'h89AB_CDEF, 1'b0, 6'd8,  5'd3, 32'h8900_0000, 1'b0};
    tbl[7] = '{32'h0123_4567, 1'b0, 6'd16, 5'd3, 32'h0123_0000, 1'b0};
    tbl[8] = '{32'hFFFF_FFFF, 1'b1, 6'd31, 5'd3, 32'hFFFF_FFFE, 1'b1};

    rst_n              = 1'b0;
    s_axis_tdata       = 32'hFFFF_FFFF;
    s_axis_tvalid      = 1'b1;
    s_axis_tlast       = 1'b0;
    m_axis_tready      = 1'b1;
    i_enable           = 1'b1;
    i_tdm_num          = 5'd2;
    i_valid_word_width = 6'd32;

    // Reset held with a pending sample.
    repeat (4) tick();
    chk("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_m_tlast",  {31'd0, m_axis_tlast},  32'd0);
    chk("rst_m_tdata",  {24'd0, m_axis_tdata},  32'd0);
    chk("rst_frame",    o_frame_num,            32'd0);
    chk("rst_error",    {31'd0, o_error},       32'd0);
    s_axis_tvalid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Vector table streamed back to back.
    clear_q();
    for (int r = 0; r < 9; r++) begin
      i_tdm_num          = tbl[r].tdm;
      i_valid_word_width = tbl[r].width;
      send_word(tbl[r].data, tbl[r].last);
      expect_word(tbl[r].exp_word, tbl[r].exp_last);
    end
    wait_drain();
    compare_stream("table");
    if (got_cyc.size() > 0 && in_cyc.size() > 0) begin
      chk("latency", got_cyc[0] - in_cyc[0], 32'd1);
      for (int i = 1; i < got_cyc.size(); i++) begin
        chk($sformatf("no_bubble%0d", i), got_cyc[i] - got_cyc[0], i);
      end
    end
    chk("table_frames", o_frame_num,      32'd6);
    chk("table_error",  {31'd0, o_error}, 32'd0);

    // Masking with backpressure on the second byte.
    clear_q();
    i_tdm_num          = 5'd1;
    i_valid_word_width = 6'd20;
    send_word(32'h1234_5678, 1'b1);
    chk("bp_byte0", {24'd0, m_axis_tdata}, 32'h12);
    tick();
    m_axis_tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_hold_data%0d", k),  {24'd0, m_axis_tdata},  32'h34);
      chk($sformatf("bp_hold_valid%0d", k), {31'd0, m_axis_tvalid}, 32'd1);
      chk($sformatf("bp_hold_last%0d", k),  {31'd0, m_axis_tlast},  32'd0);
      chk($sformatf("bp_s_tready%0d", k),   {31'd0, s_axis_tready}, 32'd0);
    end
    m_axis_tready = 1'b1;
    expect_word(32'h1234_5000, 1'b1);
    wait_drain();
    compare_stream("mask_bp");
    chk("bp_frames", o_frame_num, 32'd7);

    // Early source tlast on the second slot of a 4-slot frame.
    clear_q();
    i_tdm_num          = 5'd4;
    i_valid_word_width = 6'd32;
    send_word(32'hA0A1_A2A3, 1'b0);
    chk("early_err_before", {31'd0, o_error}, 32'd0);
    send_word(32'hB0B1_B2B3, 1'b1);
    chk("early_err_set", {31'd0, o_error}, 32'd1);
    send_word(32'hC0C1_C2C3, 1'b0);
    send_word(32'hD0D1_D2D3, 1'b0);
    send_word(32'hE0E1_E2E3, 1'b0);
    send_word(32'hF0F1_F2F3, 1'b1);
    expect_word(32'hA0A1_A2A3, 1'b0);
    expect_word(32'hB0B1_B2B3, 1'b0);
    expect_word(32'hC0C1_C2C3, 1'b0);
    expect_word(32'hD0D1_D2D3, 1'b0);
    expect_word(32'hE0E1_E2E3, 1'b0);
    expect_word(32'hF0F1_F2F3, 1'b1);
    wait_drain();
    compare_stream("early");
    chk("early_frames", o_frame_num,      32'd8);
    chk("early_sticky", {31'd0, o_error}, 32'd1);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst2_frame", o_frame_num,      32'd0);
    chk("rst2_error", {31'd0, o_error}, 32'd0);

    // tdm_num=0 selects 32 slots per frame.
    clear_q();
    i_tdm_num = 5'd0;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] w;
      w = {8'(i), 8'(i + 64), 8'(i + 128), 8'(i + 192)};
      send_word(w, i == 31);
      expect_word(w, i == 31);
    end
    wait_drain();
    compare_stream("tdm32");
    chk("tdm32_frames", o_frame_num,      32'd1);
    chk("tdm32_error",  {31'd0, o_error}, 32'd0);

    // Enable dropped mid-word: drain, block input, restart slot count.
    clear_q();
    i_tdm_num = 5'd2;
    send_word(32'h1357_9BDF, 1'b0);
    tick();
    i_enable      = 1'b0;
    s_axis_tdata  = 32'h2468_ACE0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("dis_s_tready%0d", k), {31'd0, s_axis_tready}, 32'd0);
    end
    chk("dis_no_accept", in_cyc.size(), 32'd1);
    chk("dis_m_tvalid",  {31'd0, m_axis_tvalid}, 32'd0);
    expect_word(32'h1357_9BDF, 1'b0);
    compare_stream("dis_drain");
    clear_q();
    i_enable = 1'b1;
    send_word(32'h2468_ACE0, 1'b0);
    send_word(32'hFEDC_BA98, 1'b1);
    expect_word(32'h2468_ACE0, 1'b0);
    expect_word(32'hFEDC_BA98, 1'b1);
    wait_drain();
    compare_stream("reenable");
    chk("reenable_error",  {31'd0, o_error}, 32'd0);
    chk("reenable_frames", o_frame_num,      32'd2);

    // Reset while the third byte of a word is presented.
    i_tdm_num = 5'd1;
    send_word(32'h0F1E_2D3C, 1'b1);
    tick();
    tick();
    chk("midrst_byte2", {24'd0, m_axis_tdata}, 32'h2D);
    rst_n = 1'b0;
    tick();
    chk("midrst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("midrst_m_tdata",  {24'd0, m_axis_tdata},  32'd0);
    chk("midrst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("midrst_frame",    o_frame_num,            32'd0);
    chk("midrst_error",    {31'd0, o_error},       32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("midrst_discard%0d", k), {31'd0, m_axis_tvalid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
